// File: rtl/wb_regfile.sv
// 32-entry register file with a registered write-back capture stage, bypassed read ports
// and array-only pointer-pair views; writes commit one edge after capture, stall only blocks capture.
module wb_regfile #(
   parameter int DW   = 8,
   parameter int NREG = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] wb_data,
   input  logic [4:0]    wb_addr,
   input  logic          wb_en,
   input  logic          stall,
   input  logic [4:0]    rd_addr_a,
   input  logic [4:0]    rd_addr_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   output logic [15:0]   ptr_x,
   output logic [15:0]   ptr_y,
   output logic [15:0]   ptr_z,
   output logic          wb_pending
);

   logic [DW-1:0] regs [NREG];
   logic          pend_valid;
   logic [4:0]    pend_addr;
   logic [DW-1:0] pend_data;

   // Capture and commit share an edge: the old pending entry lands while the new one is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (pend_valid) regs[pend_addr] <= pend_data;
         pend_valid <= wb_en && !stall;
         if (wb_en && !stall) begin
            pend_addr <= wb_addr;
            pend_data <= wb_data;
         end
      end
   end

   assign rd_data_a = (pend_valid && pend_addr == rd_addr_a) ? pend_data : regs[rd_addr_a];
   assign rd_data_b = (pend_valid && pend_addr == rd_addr_b) ? pend_data : regs[rd_addr_b];

   // Pointer pairs deliberately see only committed state, one edge behind the read ports.
   assign ptr_x = {regs[27], regs[26]};
   assign ptr_y = {regs[29], regs[28]};
   assign ptr_z = {regs[31], regs[30]};

   assign wb_pending = pend_valid;

endmodule
